// File: rtl/tile_blitter.sv
// Copies one tile from a registered-read tile ROM into the framebuffer at (tile_x, tile_y),
// skipping transparent-key pixels and clipping against the framebuffer edges.
module tile_blitter #(
    parameter int unsigned TILE_W    = 24,
    parameter int unsigned TILE_H    = 24,
    parameter int unsigned FB_W      = 320,
    parameter int unsigned FB_H      = 240,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned PIX_W     = 12,
    parameter int unsigned FB_ADDR_W = 17,
    parameter logic [PIX_W-1:0] TRANS_KEY = 12'hF0F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [9:0]           tile_x,
    input  logic [9:0]           tile_y,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PIX_W-1:0]     rom_pixel,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]     fb_data
);

    localparam int unsigned ColW = $clog2(TILE_W);
    localparam int unsigned RowW = $clog2(TILE_H);
    localparam int unsigned LinW = 22;
    localparam logic [10:0] FbW11 = 11'(FB_W);
    localparam logic [10:0] FbH11 = 11'(FB_H);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q;
    logic [9:0]        tile_x_q, tile_y_q;
    logic [ColW-1:0]   col_q, col1_q;
    logic [RowW-1:0]   row_q, row1_q;
    logic              v1_q;
    logic              drain_q;

    logic [10:0]       pix_x, pix_y;
    logic [LinW-1:0]   lin;
    logic              wr_ok;

    // Stage-1 coordinates line up with rom_pixel; X/Y kept at 11 bits so nothing wraps.
    always_comb begin
        pix_x = 11'(tile_x_q) + 11'(col1_q);
        pix_y = 11'(tile_y_q) + 11'(row1_q);
        lin   = LinW'(pix_y) * LinW'(FB_W) + LinW'(pix_x);
        wr_ok = v1_q && (rom_pixel != TRANS_KEY) && (pix_x < FbW11) && (pix_y < FbH11);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
            rom_addr <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            tile_x_q <= '0;
            tile_y_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            col1_q   <= '0;
            row1_q   <= '0;
            v1_q     <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            v1_q   <= (state_q == StFetch);
            col1_q <= col_q;
            row1_q <= row_q;
            fb_we  <= wr_ok;
            if (wr_ok) begin
                fb_addr <= FB_ADDR_W'(lin);
                fb_data <= rom_pixel;
            end
            done <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        tile_x_q <= tile_x;
                        tile_y_q <= tile_y;
                        col_q    <= '0;
                        row_q    <= '0;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                        state_q  <= StFetch;
                    end
                end
                StFetch: begin
                    if (col_q == ColW'(TILE_W - 1) && row_q == RowW'(TILE_H - 1)) begin
                        drain_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        if (col_q == ColW'(TILE_W - 1)) begin
                            col_q <= '0;
                            row_q <= row_q + RowW'(1);
                        end else begin
                            col_q <= col_q + ColW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (drain_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                StDone: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_blitter.sv
// Directed bench for tile_blitter: per-cycle comparison against a tile-level model of the
// expected ROM addresses, write strobes and handshake, plus hand-computed anchor values.
module tb_tile_blitter;

    localparam int FBW = 320;
    localparam int FBH = 240;
    localparam int TW  = 24;
    localparam int N   = 576;
    localparam logic [11:0] KEY = 12'hF0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  tile_x = '0;
    logic [9:0]  tile_y = '0;
    logic        busy, done, fb_we;
    logic [9:0]  rom_addr;
    logic [11:0] rom_pixel = '0;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;

    tile_blitter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tile_x    (tile_x),
        .tile_y    (tile_y),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_pixel (rom_pixel),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data)
    );

    always #5 clk = ~clk;

    logic [11:0] rom_mem [0:1023];
    always @(posedge clk) rom_pixel <= rom_mem[rom_addr];

    int total = 0;
    int bad   = 0;
    int m_addr = 0;
    int m_data = 0;
    int pin_a2, pin_d2, pin_a577, pin_d577;
    bit hit_skip;

    task automatic check(input string name, input int c, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    function automatic bit pix_written(input int x, input int y, input int k);
        return (rom_mem[k] != KEY) && (x + k % TW < FBW) && (y + k / TW < FBH);
    endfunction

    task automatic fill_rom(input bit with_key);
        for (int k = 0; k < 1024; k++) rom_mem[k] = with_key ? 12'(k + 1) : 12'(k);
        if (with_key) rom_mem[5] = KEY;
    endtask

    // One tile transfer; optional start re-pulses at cycles 100/578 and optional reset.
    task automatic run(input int x, input int y, input bit repulse, input int rst_at,
                       input int exp_writes);
        int nw, done_cyc, busy_cnt, k, exp_ra, ndone_after;
        bit exp_we;
        @(negedge clk);
        tile_x = 10'(x);
        tile_y = 10'(y);
        start  = 1'b1;
        @(negedge clk);
        nw = 0; done_cyc = -1; busy_cnt = 0; hit_skip = 1'b0;
        for (int c = 0; c <= 581; c++) begin
            if (c > 0) @(negedge clk);
            start = 1'b0;
            if (rst_at >= 0 && c == rst_at + 1) begin
                check("rst_busy", c, 32'(busy), 0);
                check("rst_done", c, 32'(done), 0);
                check("rst_fb_we", c, 32'(fb_we), 0);
                check("rst_rom_addr", c, 32'(rom_addr), 0);
                rst = 1'b0;
                m_addr = 0;
                m_data = 0;
                ndone_after = 0;
                nw = 0;
                for (int j = 0; j < 600; j++) begin
                    @(negedge clk);
                    if (done) ndone_after++;
                    if (fb_we) nw++;
                end
                check("no_done_after_rst", c, 32'(ndone_after), 0);
                check("no_write_after_rst", c, 32'(nw), 0);
                return;
            end
            k      = c - 2;
            exp_we = (k >= 0 && k < N) ? pix_written(x, y, k) : 1'b0;
            if (exp_we) begin
                m_addr = (y + k / TW) * FBW + x + k % TW;
                m_data = int'(rom_mem[k]);
            end
            exp_ra = (c < N) ? c : N - 1;
            check("rom_addr", c, 32'(rom_addr), 32'(exp_ra));
            check("busy", c, 32'(busy), 32'(c <= 577));
            check("done", c, 32'(done), 32'(c == 578));
            check("fb_we", c, 32'(fb_we), 32'(exp_we));
            check("fb_addr", c, 32'(fb_addr), 32'(m_addr));
            check("fb_data", c, 32'(fb_data), 32'(m_data));
            if (busy) busy_cnt++;
            if (done && done_cyc < 0) done_cyc = c;
            if (fb_we) nw++;
            if (fb_we && int'(fb_addr) == y * FBW + x + 5) hit_skip = 1'b1;
            if (c == 2)   begin pin_a2 = int'(fb_addr);   pin_d2 = int'(fb_data);   end
            if (c == 577) begin pin_a577 = int'(fb_addr); pin_d577 = int'(fb_data); end
            if (repulse && (c == 100 || c == 578)) begin
                start  = 1'b1;
                tile_x = '0;
                tile_y = '0;
            end
            if (c == rst_at) rst = 1'b1;
        end
        check("write_count", 0, 32'(nw), 32'(exp_writes));
        check("done_cycle", 0, 32'(done_cyc), 578);
        check("busy_cycles", 0, 32'(busy_cnt), 578);
    endtask

    initial begin
        fill_rom(1'b0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 0, 32'(busy), 0);
        check("reset_done", 0, 32'(done), 0);
        check("reset_rom_addr", 0, 32'(rom_addr), 0);
        check("reset_fb_we", 0, 32'(fb_we), 0);
        check("reset_fb_addr", 0, 32'(fb_addr), 0);
        check("reset_fb_data", 0, 32'(fb_data), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run(10, 20, 1'b0, -1, 576);
        check("first_addr", 2, 32'(pin_a2), 6410);
        check("first_data", 2, 32'(pin_d2), 0);
        check("last_addr", 577, 32'(pin_a577), 13793);
        check("last_data", 577, 32'(pin_d577), 575);

        fill_rom(1'b1);
        run(10, 20, 1'b0, -1, 575);
        check("key_skipped", 0, 32'(hit_skip), 0);

        fill_rom(1'b0);
        run(310, 230, 1'b0, -1, 100);
        run(400, 0, 1'b0, -1, 0);
        run(50, 60, 1'b1, -1, 576);
        run(10, 20, 1'b0, -1, 576);

        run(10, 20, 1'b0, 300, 0);
        run(10, 20, 1'b0, -1, 576);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
